iob_axistream_out_arb: RTL and testbench
========================================

# iob_axistream_out_arb

Packet-granular round-robin arbiter that merges `N_IN` byte-wide AXI-Stream sources, each carrying tdata, tvalid, tready and tlast, into one output stream. The output stream feeds the `tdata`/`tvalid`/`tready`/`tlast` port of the AXI-Stream output peripheral. A grant is held from a packet's first beat to its `tlast` beat, so packets from different sources never interleave. The output is registered to cut the combinational path between sources and sink.

## Interface

Parameters:
- `N_IN`, default 2: number of source streams (2 to 8).
- `DATA_W`, default 8: tdata width per stream.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_tdata`  in  N_IN*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
- `in_tvalid`  in  N_IN  source valid, one bit per source.
- `in_tlast`  in  N_IN  source end-of-packet, one bit per source.
- `in_tready`  out  N_IN  per-source ready; one-hot or zero.
- `out_tdata`  out  DATA_W  merged data, registered.
- `out_tvalid`  out  1  merged valid, registered.
- `out_tlast`  out  1  merged end-of-packet, registered.
- `out_tready`  in  1  sink ready.
- `grant`  out  N_IN  one-hot index of the current owner; zero when idle.
- `busy`  out  1  high while state is PKT.

## Operation

- FSM states:
  - IDLE: no owner.
  - PKT: `grant` is held.
- IDLE → PKT:
  - Transition happens when any `in_tvalid` bit is high.
  - The winner is the first set bit scanning upward and wrapping, starting at `(last+1) mod N_IN`, where `last` is the index of the previous winner.
  - On the transition, `grant` is set to the winner and `last` is updated to the winner's index.
- PKT → IDLE: on the accepted beat from the owner that has `in_tlast=1`.
  - `grant` clears on the same edge.
  - At least one IDLE cycle always separates consecutive packets.
- `in_tready[g] = busy & grant[g] & (~out_tvalid | out_tready)`. All other ready bits are 0.
- A beat is accepted when `in_tvalid[g] & in_tready[g]`. On acceptance:
  - The owner's tdata and tlast are loaded into `out_tdata`/`out_tlast`.
  - `out_tvalid` is set to 1.
- Output register update rules:
  - Output beat accepted (`out_tvalid & out_tready`) with no new input beat: `out_tvalid` goes to 0. `out_tdata`/`out_tlast` hold their values, which are don't-care.
  - `out_tvalid=1` and `out_tready=0`: `out_tdata`/`out_tlast` hold. No new beat is accepted.
- Source `tvalid` deasserting inside a packet: grant is held, no beat is accepted, and there is no timeout.
- Sources raising `tvalid` while another source owns the grant are not served until the owner's `tlast` has been accepted.
- Single-beat packet (first beat has `tlast=1`): PKT lasts exactly the cycles needed to accept that beat.
- Reset mid-packet: the FSM, `grant`, the output register and `last` are all reset. The in-flight packet is truncated, with no `tlast` on the output. Recovering from that is the software's responsibility.

## Timing

- Reset values:
  - `out_tvalid=0`, `out_tdata=0`, `out_tlast=0`.
  - `in_tready=0`, `grant=0`, `busy=0`, FSM in IDLE.
  - `last=N_IN-1`, so input 0 has first priority.
- Arbitration latency: `in_tvalid` is sampled high in IDLE at edge k, and `grant`/`busy` are high after edge k.
  - `in_tready` can be high in cycle k+1 when the output register is free.
- Forward latency: a beat accepted at edge n appears on `out_*` with `out_tvalid=1` after edge n.
- Throughput: 1 beat per cycle within a packet while `out_tready=1`.
- Packet turnaround: 1 idle cycle after a `tlast` acceptance before the next grant is issued.
- AXI-Stream rules on the output side:
  - Once `out_tvalid` is asserted, it and `out_tdata`/`out_tlast` are stable until accepted.
  - `out_tvalid` does not depend combinationally on `out_tready`.
- `in_tready` is combinational from `out_tready`, `out_tvalid`, `grant` and `busy` only. It has no path from `in_tvalid`.

## Test plan

- Reset then idle. Hold `rst`=1 for 2 cycles with all `in_tvalid`=1; check all outputs are 0. Release reset with `in_tvalid`=0; check `grant`, `busy` and `out_tvalid` stay 0 for 10 cycles.
- Single source. With `N_IN`=2 and `out_tready`=1, source 0 sends the 4-beat packet 0x11, 0x22, 0x33, 0x44 (tlast on 0x44).
  - Check `grant`=01 one cycle after `in_tvalid`.
  - Check `out_tdata` shows 0x11..0x44 on consecutive cycles, with `out_tlast` only on 0x44.
  - Check `grant`=00 after the tlast edge.
- Round-robin fairness. Sources 0 and 1 continuously offer 2-beat packets (0xA0, 0xA1 and 0xB0, 0xB1).
  - Check the output alternates A, B, A, B, with no beats from different sources interleaved inside a packet.
  - Check exactly one IDLE cycle separates packets.
- Backpressure. During source 0's 3-beat packet 0x01, 0x02, 0x03, drive `out_tready`=0 for 5 cycles after the first output beat.
  - Check `out_tdata`=0x01 and `out_tvalid`=1 are held stable throughout.
  - Check `in_tready[0]`=0 throughout.
  - Check no beat is lost or duplicated after `out_tready` returns to 1.
- Source gap and late requester. Source 1 stalls `in_tvalid` for 3 cycles mid-packet while source 0 raises `in_tvalid`.
  - Check `grant` stays 10 until source 1's tlast is accepted.
  - Then check source 0 is granted.
- Reset mid-packet. Assert `rst` for 1 cycle after the 2nd beat of a 5-beat packet.
  - Check all outputs return to their reset values the next cycle.
  - Check the next grant goes to input 0 first.

Source files
------------

// File: rtl/iob_axistream_out_arb.sv
// iob_axistream_out_arb
// Packet-granular round-robin arbiter that merges N_IN AXI-Stream sources
// into one registered output stream. A grant is held from a packet's first
// beat to its tlast beat, so packets from different sources never interleave.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_tdata        N_IN*DATA_W source data, source i at [i*DATA_W +: DATA_W]
//   in_tvalid       per-source valid
//   in_tlast        per-source end-of-packet
//   in_tready       per-source ready (one-hot or zero)
//   out_tdata       merged data (registered)
//   out_tvalid      merged valid (registered)
//   out_tlast       merged end-of-packet (registered)
//   out_tready      sink ready
//   grant           one-hot current owner, zero when idle
//   busy            high while a packet is in progress
module iob_axistream_out_arb #(
  parameter int N_IN   = 2,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_tdata,
  input  logic [N_IN-1:0]        in_tvalid,
  input  logic [N_IN-1:0]        in_tlast,
  output logic [N_IN-1:0]        in_tready,
  output logic [DATA_W-1:0]      out_tdata,
  output logic                   out_tvalid,
  output logic                   out_tlast,
  input  logic                   out_tready,
  output logic [N_IN-1:0]        grant,
  output logic                   busy
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [N_IN-1:0]   grant_r, grant_s;
  logic [IW-1:0]     last_r, last_s;
  logic [DATA_W-1:0] out_tdata_r;
  logic              out_tvalid_r;
  logic              out_tlast_r;

  logic              found_s;
  logic [IW-1:0]     win_s;
  logic              out_free_s;
  logic              accept_s;
  logic [DATA_W-1:0] own_tdata_s;
  logic              own_tlast_s;

  assign busy       = (state_r == PKT);
  assign grant      = grant_r;
  assign out_tdata  = out_tdata_r;
  assign out_tvalid = out_tvalid_r;
  assign out_tlast  = out_tlast_r;

  // Output register can take a beat when empty or being drained this cycle.
  // Ready never looks at in_tvalid, so no valid->ready loop exists.
  assign out_free_s = ~out_tvalid_r | out_tready;
  assign in_tready  = grant_r & {N_IN{busy & out_free_s}};
  assign accept_s   = |(in_tvalid & in_tready);
  assign own_tlast_s = |(in_tlast & grant_r);

  // AND-OR mux of the owner's data; grant_r is one-hot so at most one term is live
  always_comb begin
    own_tdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      own_tdata_s = own_tdata_s | (in_tdata[i*DATA_W +: DATA_W] & {DATA_W{grant_r[i]}});
    end
  end

  // Round-robin pick: first requester above last_r, otherwise wrap to the
  // first requester at or below it (last_r itself has lowest priority)
  always_comb begin
    found_s = 1'b0;
    win_s   = last_r;
    for (int i = 0; i < N_IN; i++) begin
      if (!found_s && in_tvalid[i] && (IW'(i) > last_r)) begin
        found_s = 1'b1;
        win_s   = IW'(i);
      end else begin
        win_s = win_s;
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (!found_s && in_tvalid[i] && (IW'(i) <= last_r)) begin
        found_s = 1'b1;
        win_s   = IW'(i);
      end else begin
        win_s = win_s;
      end
    end
  end

  // FSM next-state, grant and round-robin pointer
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = PKT;
          grant_s = N_IN'(1'b1) << win_s;
          last_s  = win_s;
        end else begin
          state_s = IDLE;
        end
      end
      PKT: begin
        // Grant drops on the tlast acceptance edge, forcing one idle cycle
        if (accept_s && own_tlast_s) begin
          state_s = IDLE;
          grant_s = {N_IN{1'b0}};
        end else begin
          state_s = PKT;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {N_IN{1'b0}};
      end
    endcase
  end

  // FSM state, grant and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= {N_IN{1'b0}};
      last_r  <= IW'(N_IN - 1);
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
    end
  end

  // Output skid-free register: load on acceptance, clear valid on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_tdata_r  <= {DATA_W{1'b0}};
      out_tvalid_r <= 1'b0;
      out_tlast_r  <= 1'b0;
    end else if (accept_s) begin
      out_tdata_r  <= own_tdata_s;
      out_tvalid_r <= 1'b1;
      out_tlast_r  <= own_tlast_s;
    end else if (out_tvalid_r && out_tready) begin
      out_tvalid_r <= 1'b0;
    end else begin
      out_tvalid_r <= out_tvalid_r;
    end
  end

endmodule

// File: tb/tb_iob_axistream_out_arb.sv
// Self-checking bench for iob_axistream_out_arb (N_IN=2, DATA_W=8).
// Sources are driven from per-source beat queues; expected output beats are
// pushed into a scoreboard when stimulus is issued and popped by a monitor
// on every output handshake.
module tb_iob_axistream_out_arb;

  typedef struct packed {
    logic       v;
    logic       l;
    logic [7:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_tdata = '0;
  logic [1:0]  in_tvalid = '0;
  logic [1:0]  in_tlast = '0;
  logic [1:0]  in_tready;
  logic [7:0]  out_tdata;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready = 1'b1;
  logic [1:0]  grant;
  logic        busy;

  int tests = 0;
  int fails = 0;

  beat_t sq0[$];
  beat_t sq1[$];
  logic [8:0] sb[$];
  logic [1:0] acc_r = '0;
  logic       drv0 = 1'b0;
  logic       drv1 = 1'b0;

  iob_axistream_out_arb #(.N_IN(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic beat_t bt(input logic v, input logic l, input logic [7:0] d);
    bt.v = v;
    bt.l = l;
    bt.d = d;
  endfunction

  // Capture source handshakes with pre-edge values
  always @(posedge clk) acc_r <= in_tvalid & in_tready;

  // Source drivers: retire an accepted beat (or a one-cycle bubble), present the next
  always @(negedge clk) begin
    if (drv0 && sq0.size() > 0 && (acc_r[0] || !sq0[0].v)) void'(sq0.pop_front());
    if (sq0.size() > 0) begin
      in_tvalid[0]    = sq0[0].v;
      in_tlast[0]     = sq0[0].l;
      in_tdata[7:0]   = sq0[0].d;
      drv0            = 1'b1;
    end else begin
      in_tvalid[0]    = 1'b0;
      in_tlast[0]     = 1'b0;
      drv0            = 1'b0;
    end
    if (drv1 && sq1.size() > 0 && (acc_r[1] || !sq1[0].v)) void'(sq1.pop_front());
    if (sq1.size() > 0) begin
      in_tvalid[1]    = sq1[0].v;
      in_tlast[1]     = sq1[0].l;
      in_tdata[15:8]  = sq1[0].d;
      drv1            = 1'b1;
    end else begin
      in_tvalid[1]    = 1'b0;
      in_tlast[1]     = 1'b0;
      drv1            = 1'b0;
    end
  end

  // Monitor: every output handshake must match the next scoreboard entry
  always @(negedge clk) begin
    if (out_tvalid && out_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {23'd0, out_tlast, out_tdata}, 32'h1ff);
      end else begin
        chk("out_beat", {23'd0, out_tlast, out_tdata}, {23'd0, sb.pop_front()});
      end
    end
  end

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sq0.size() == 0 && sq1.size() == 0 && grant == 2'b00 && !out_tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
    tick();
  endtask

  logic [1:0] rr_grant [8];
  logic       rr_busy  [8];

  initial begin
    // ---- Reset with all sources requesting, then idle ----
    sq0.push_back(bt(1'b1, 1'b0, 8'hEE));
    sq1.push_back(bt(1'b1, 1'b0, 8'hDD));
    tick();
    tick();
    chk("rst_outs", {out_tdata, out_tvalid, out_tlast, in_tready, grant, busy}, 32'd0);
    sq0.delete();
    sq1.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_quiet", {grant, busy, out_tvalid}, 32'd0);
    end

    // ---- Single source, 4-beat packet ----
    sq0.push_back(bt(1'b1, 1'b0, 8'h11)); sb.push_back({1'b0, 8'h11});
    sq0.push_back(bt(1'b1, 1'b0, 8'h22)); sb.push_back({1'b0, 8'h22});
    sq0.push_back(bt(1'b1, 1'b0, 8'h33)); sb.push_back({1'b0, 8'h33});
    sq0.push_back(bt(1'b1, 1'b1, 8'h44)); sb.push_back({1'b1, 8'h44});
    tick();
    chk("single_grant", {30'd0, grant}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_stream_valid", {31'd0, out_tvalid}, 32'd1);
    end
    chk("single_grant_clear", {29'd0, grant, busy}, 32'd0);
    wait_idle();

    // ---- Round robin: last winner was 0, so source 1 goes first ----
    for (int k = 0; k < 2; k++) begin
      sq0.push_back(bt(1'b1, 1'b0, 8'hA0));
      sq0.push_back(bt(1'b1, 1'b1, 8'hA1));
      sq1.push_back(bt(1'b1, 1'b0, 8'hB0));
      sq1.push_back(bt(1'b1, 1'b1, 8'hB1));
    end
    for (int k = 0; k < 2; k++) begin
      sb.push_back({1'b0, 8'hB0}); sb.push_back({1'b1, 8'hB1});
      sb.push_back({1'b0, 8'hA0}); sb.push_back({1'b1, 8'hA1});
    end
    rr_grant = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    rr_busy  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_grant", {30'd0, grant}, {30'd0, rr_grant[i]});
      chk("rr_busy", {31'd0, busy}, {31'd0, rr_busy[i]});
    end
    wait_idle();

    // ---- Backpressure on source 0's 3-beat packet ----
    sq0.push_back(bt(1'b1, 1'b0, 8'h01)); sb.push_back({1'b0, 8'h01});
    sq0.push_back(bt(1'b1, 1'b0, 8'h02)); sb.push_back({1'b0, 8'h02});
    sq0.push_back(bt(1'b1, 1'b1, 8'h03)); sb.push_back({1'b1, 8'h03});
    tick();
    chk("bp_grant", {30'd0, grant}, 32'd1);
    tick();
    out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", {24'd0, out_tdata}, 32'h01);
      chk("bp_hold_valid", {31'd0, out_tvalid}, 32'd1);
      chk("bp_in_tready", {31'd0, in_tready[0]}, 32'd0);
    end
    out_tready = 1'b1;
    wait_idle();

    // ---- Source 1 gaps mid-packet while source 0 requests ----
    sq1.push_back(bt(1'b1, 1'b0, 8'hC0)); sb.push_back({1'b0, 8'hC0});
    sq1.push_back(bt(1'b1, 1'b0, 8'hC1)); sb.push_back({1'b0, 8'hC1});
    sq1.push_back(bt(1'b0, 1'b0, 8'h00));
    sq1.push_back(bt(1'b0, 1'b0, 8'h00));
    sq1.push_back(bt(1'b0, 1'b0, 8'h00));
    sq1.push_back(bt(1'b1, 1'b1, 8'hC2)); sb.push_back({1'b1, 8'hC2});
    sb.push_back({1'b1, 8'hD0});
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) sq0.push_back(bt(1'b1, 1'b1, 8'hD0));
      chk("gap_grant_held", {30'd0, grant}, 32'd2);
    end
    tick();
    chk("gap_grant_clear", {30'd0, grant}, 32'd0);
    tick();
    chk("gap_late_grant", {30'd0, grant}, 32'd1);
    wait_idle();

    // ---- Reset mid-packet after the 2nd beat ----
    sq0.push_back(bt(1'b1, 1'b0, 8'hE0)); sb.push_back({1'b0, 8'hE0});
    sq0.push_back(bt(1'b1, 1'b0, 8'hE1)); sb.push_back({1'b0, 8'hE1});
    sq0.push_back(bt(1'b1, 1'b0, 8'hE2));
    sq0.push_back(bt(1'b1, 1'b0, 8'hE3));
    sq0.push_back(bt(1'b1, 1'b1, 8'hE4));
    tick();
    tick();
    tick();
    chk("mid_second_beat", {24'd0, out_tdata}, 32'hE1);
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", {out_tdata, out_tvalid, out_tlast, in_tready, grant, busy}, 32'd0);
    sq0.delete();
    rst = 1'b0;
    tick();
    // Pointer is back to N_IN-1, so source 0 must win over source 1
    sq0.push_back(bt(1'b1, 1'b1, 8'hF0)); sb.push_back({1'b1, 8'hF0});
    sq1.push_back(bt(1'b1, 1'b1, 8'h60)); sb.push_back({1'b1, 8'h60});
    tick();
    chk("post_rst_grant", {30'd0, grant}, 32'd1);
    wait_idle();

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a wait misbehaves
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
